div_pow2_pipe: RTL and testbench

//  Pipelined signed divide-by-2^y with selectable rounding and valid/ready handshake.

---
 rtl/div_pow2_pkg.sv | 28 ++
 rtl/div_pow2_round.sv | 23 ++
 rtl/div_pow2_pipe.sv | 118 +++++++++++
 tb/tb_div_pow2_pipe.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pow2_pkg.sv
// Shared types and the rounding-increment rule for the divide-by-2^y pipeline.
package div_pow2_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    TRUNC   = 2'd0,
    FLOOR   = 2'd1,
    NEAREST = 2'd2,
    RSVD    = 2'd3
  } round_mode_t;

  // Increment applied to the floor quotient; RSVD behaves as TRUNC.
  function automatic logic round_incr(input round_mode_t mode,
                                      input logic sign,
                                      input logic guard,
                                      input logic sticky,
                                      input logic y_is_zero);
    logic incr;
    case (mode)
      FLOOR:   incr = 1'b0;
      NEAREST: incr = guard & (sticky | ~sign);
      default: incr = sign & (guard | sticky);
    endcase
    return incr & ~y_is_zero;
  endfunction

endpackage

// File: rtl/div_pow2_round.sv
// Second-stage core: turns the floor quotient plus guard/sticky into the rounded result.
module div_pow2_round
  import div_pow2_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] q_f,
  input  logic         guard,
  input  logic         sticky,
  input  logic         sign,
  input  logic         y_zero,
  input  round_mode_t  mode,
  output logic [W-1:0] q,
  output logic         inexact
);

  logic incr;

  assign incr    = round_incr(mode, sign, guard, sticky, y_zero);
  assign q       = q_f + {{(W-1){1'b0}}, incr};
  assign inexact = guard | sticky;

endmodule

// File: rtl/div_pow2_pipe.sv
// Two-stage pipelined signed divide-by-2^y with selectable rounding and valid/ready flow control.
module div_pow2_pipe
  import div_pow2_pkg::*;
#(
  parameter int W     = 8,
  parameter int SW    = $clog2(W) + 1,
  parameter int TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [W-1:0]     x_i,
  input  logic [SW-1:0]    y_i,
  input  logic [1:0]       mode_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [W-1:0]     output__,
  output logic             inexact_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int XW = W + 1;
  localparam int YW = SW + 1;

  logic [YW-1:0]    ys;
  logic [XW-1:0]    xe;
  logic [XW-1:0]    half;
  logic [W-1:0]     q_f;
  logic             guard;
  logic             sticky;

  logic             s1_valid;
  logic [W-1:0]     s1_qf;
  logic             s1_guard;
  logic             s1_sticky;
  logic             s1_sign;
  logic             s1_yz;
  round_mode_t      s1_mode;
  logic [TAG_W-1:0] s1_tag;

  logic [W-1:0]     r_q;
  logic             r_inexact;
  logic             s2_adv;

  // Shifts beyond W+1 behave exactly like W+1: the whole dividend is below the
  // guard position, and the guard itself is just the sign extension.
  always_comb begin
    ys     = ({1'b0, y_i} > YW'(W)) ? YW'(W + 1) : {1'b0, y_i};
    xe     = {x_i[W-1], x_i};
    q_f    = $signed(x_i) >>> ys;
    half   = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    if (ys != '0) begin
      half   = XW'(1) << (ys - YW'(1));
      guard  = |(xe & half);
      sticky = |(xe & (half - XW'(1)));
    end
  end

  assign s2_adv     = ~out_valid_o | out_ready_i;
  assign in_ready_o = ~s1_valid | s2_adv;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid  <= 1'b0;
      s1_qf     <= '0;
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
      s1_sign   <= 1'b0;
      s1_yz     <= 1'b0;
      s1_mode   <= TRUNC;
      s1_tag    <= '0;
    end else if (in_ready_o) begin
      s1_valid <= in_valid_i;
      if (in_valid_i) begin
        s1_qf     <= q_f;
        s1_guard  <= guard;
        s1_sticky <= sticky;
        s1_sign   <= x_i[W-1];
        s1_yz     <= (y_i == '0);
        s1_mode   <= round_mode_t'(mode_i);
        s1_tag    <= tag_i;
      end
    end
  end

  div_pow2_round #(.W(W)) u_round (
    .q_f     (s1_qf),
    .guard   (s1_guard),
    .sticky  (s1_sticky),
    .sign    (s1_sign),
    .y_zero  (s1_yz),
    .mode    (s1_mode),
    .q       (r_q),
    .inexact (r_inexact)
  );

  // Output registers only load on a real transfer, so they hold while stalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      output__    <= '0;
      inexact_o   <= 1'b0;
      tag_o       <= '0;
    end else if (s2_adv) begin
      out_valid_o <= s1_valid;
      if (s1_valid) begin
        output__  <= r_q;
        inexact_o <= r_inexact;
        tag_o     <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_div_pow2_pipe.sv
// Self-checking bench for div_pow2_pipe against an integer-arithmetic division model.
module tb_div_pow2_pipe;

  localparam int W     = 8;
  localparam int SW    = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     x;
  logic [SW-1:0]    y;
  logic [1:0]       mode;
  logic [TAG_W-1:0] tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     q_out;
  logic             inexact;
  logic [TAG_W-1:0] tag_out;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct { int q; bit inx; int tag; } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  div_pow2_pipe #(.W(W), .SW(SW), .TAG_W(TAG_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .x_i         (x),
    .y_i         (y),
    .mode_i      (mode),
    .tag_i       (tag),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .output__    (q_out),
    .inexact_o   (inexact),
    .tag_o       (tag_out)
  );

  // Reference: exact floor division by 2^y, remainder, then the rounding rule.
  function automatic void ref_div(input int xv, input int yv, input int mv,
                                  output int qv, output bit inx);
    longint d, qf, r, half;
    d = longint'(1) << yv;
    if (xv >= 0) qf = longint'(xv) / d;
    else         qf = -((longint'(-xv) + d - 1) / d);
    r   = longint'(xv) - qf * d;
    inx = (r != 0);
    case (mv)
      1: qv = int'(qf);
      2: begin
        if (yv == 0) qv = xv;
        else begin
          half = d / 2;
          qv = int'(qf + ((r > half) ? 1 : 0) + ((r == half && xv >= 0) ? 1 : 0));
        end
      end
      default: qv = int'(qf + ((xv < 0 && r != 0) ? 1 : 0));
    endcase
  endfunction

  task automatic push_exp();
    exp_t e;
    int   qv;
    bit   ix;
    ref_div(int'($signed(x)), int'(y), int'(mode), qv, ix);
    e.q = qv; e.inx = ix; e.tag = int'(tag);
    sb.push_back(e);
  endtask

  task automatic randomize_inputs();
    x    = W'($urandom);
    y    = SW'($urandom);
    mode = 2'($urandom);
    tag  = TAG_W'($urandom);
  endtask

  // Drives one isolated transaction and returns what came out (or got=0 on timeout).
  task automatic run_one(input int xv, input int yv, input int mv, input int tv,
                         output bit got, output int qv, output bit inx);
    x = W'(xv); y = SW'(yv); mode = 2'(mv); tag = TAG_W'(tv);
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    got = 1'b0; qv = 0; inx = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      #1;
      if (out_valid === 1'b1) begin
        got = 1'b1; qv = int'($signed(q_out)); inx = inexact;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; mode = '0; tag = '0;
    @(negedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0 || q_out !== '0 || inexact !== 1'b0 || tag_out !== '0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b q=%h inx=%b tag=%h, expected all zero",
               out_valid, q_out, inexact, tag_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_valid: got %b expected 0", out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_exhaustive();
    int   total = 256 * 10 * 4;
    int   idx = 0;
    int   cyc = 0;
    exp_t e;
    out_ready = 1'b1;
    while ((idx < total || sb.size() != 0) && cyc < total + 50) begin
      if (idx < total) begin
        in_valid = 1'b1;
        x    = idx[7:0];
        y    = SW'((idx / 256) % 10);
        mode = 2'(idx / 2560);
        tag  = idx[3:0];
      end else in_valid = 1'b0;
      #1;
      if (out_valid === 1'b1) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL exh_spurious: output q=%0d with nothing expected", $signed(q_out));
        end else begin
          e = sb.pop_front();
          if (q_out !== W'(e.q) || inexact !== e.inx || tag_out !== TAG_W'(e.tag)) begin
            n_fail++;
            $display("FAIL exh_result: got q=%0d inx=%b tag=%0d expected q=%0d inx=%b tag=%0d",
                     $signed(q_out), inexact, tag_out, e.q, e.inx, e.tag);
          end
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        push_exp();
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    if (idx < total || sb.size() != 0) begin
      n_vec++; n_fail++;
      $display("FAIL exh_timeout: sent %0d of %0d, %0d outstanding", idx, total, sb.size());
      sb.delete();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_ties();
    int tx[6] = '{5, -5, -128, -128, -5, -5};
    int ty[6] = '{1, 1, 8, 9, 1, 1};
    int tm[6] = '{2, 2, 2, 2, 0, 1};
    int tq[6] = '{3, -3, -1, 0, -2, -3};
    bit got, inx;
    int qv;
    for (int i = 0; i < 6; i++) begin
      run_one(tx[i], ty[i], tm[i], i, got, qv, inx);
      n_vec++;
      if (!got) begin
        n_fail++;
        $display("FAIL ties_timeout[%0d]: no output", i);
      end else if (qv !== tq[i] || inx !== 1'b1) begin
        n_fail++;
        $display("FAIL ties[%0d]: x=%0d y=%0d m=%0d got q=%0d inx=%b expected q=%0d inx=1",
                 i, tx[i], ty[i], tm[i], qv, inx, tq[i]);
      end
    end
  endtask

  task automatic test_y0_rsvd();
    int tx[5] = '{-1, -7, 100, -128, 127};
    int ty[5] = '{0, 2, 0, 15, 15};
    int tm[5] = '{3, 3, 2, 1, 0};
    int tq[5] = '{-1, -1, 100, -1, 0};
    bit ti[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bit got, inx;
    int qv;
    for (int i = 0; i < 5; i++) begin
      run_one(tx[i], ty[i], tm[i], i, got, qv, inx);
      n_vec++;
      if (!got) begin
        n_fail++;
        $display("FAIL y0_rsvd_timeout[%0d]: no output", i);
      end else if (qv !== tq[i] || inx !== ti[i]) begin
        n_fail++;
        $display("FAIL y0_rsvd[%0d]: x=%0d y=%0d m=%0d got q=%0d inx=%b expected q=%0d inx=%b",
                 i, tx[i], ty[i], tm[i], qv, inx, tq[i], ti[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int   acc = 0;
    bit   held = 1'b0;
    bit   took;
    logic [W-1:0]     hq;
    logic [TAG_W-1:0] ht;
    logic             hi;
    exp_t e;
    int   seen = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    randomize_inputs();
    tag = TAG_W'(1);
    for (int c = 0; c < 5; c++) begin
      #1;
      if (out_valid === 1'b1) begin
        if (!held) begin
          hq = q_out; ht = tag_out; hi = inexact; held = 1'b1;
        end else begin
          n_vec++;
          if (q_out !== hq || tag_out !== ht || inexact !== hi) begin
            n_fail++;
            $display("FAIL bp_hold: q=%h tag=%h inx=%b changed from q=%h tag=%h inx=%b",
                     q_out, tag_out, inexact, hq, ht, hi);
          end
        end
      end
      took = in_valid && in_ready === 1'b1;
      if (took) push_exp();
      @(negedge clk);
      if (took) begin
        acc++;
        if (acc < 3) begin randomize_inputs(); tag = TAG_W'(acc + 1); end
      end
    end
    #1;
    n_vec++;
    if (acc != 2) begin
      n_fail++;
      $display("FAIL bp_accept_count: got %0d expected 2", acc);
    end
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_in_ready: got %b expected 0", in_ready);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (acc < 3 || sb.size() != 0); c++) begin
      #1;
      if (out_valid === 1'b1) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL bp_spurious: tag=%0d with nothing expected", tag_out);
        end else begin
          e = sb.pop_front();
          seen++;
          if (tag_out !== TAG_W'(seen) || q_out !== W'(e.q) || inexact !== e.inx) begin
            n_fail++;
            $display("FAIL bp_order: got tag=%0d q=%0d inx=%b expected tag=%0d q=%0d inx=%b",
                     tag_out, $signed(q_out), inexact, seen, e.q, e.inx);
          end
        end
      end
      took = in_valid && in_ready === 1'b1;
      if (took) push_exp();
      @(negedge clk);
      if (took) begin acc++; in_valid = 1'b0; end
    end
    n_vec++;
    if (seen != 3 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL bp_release: got %0d results expected 3", seen);
      sb.delete();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_streaming();
    int first_acc = -1, first_out = -1, n_out = 0;
    exp_t e;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      randomize_inputs();
      #1;
      if (out_valid === 1'b1) begin
        if (first_out < 0) first_out = c;
        n_out++;
        n_vec++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL stream_spurious: output with nothing expected");
        end else begin
          e = sb.pop_front();
          if (q_out !== W'(e.q) || inexact !== e.inx || tag_out !== TAG_W'(e.tag)) begin
            n_fail++;
            $display("FAIL stream_result: got q=%0d inx=%b tag=%0d expected q=%0d inx=%b tag=%0d",
                     $signed(q_out), inexact, tag_out, e.q, e.inx, e.tag);
          end
        end
      end
      if (in_ready === 1'b1) begin
        if (first_acc < 0) first_acc = c;
        push_exp();
      end
      @(negedge clk);
    end
    n_vec++;
    if (first_acc < 0 || first_out < 0 || first_out - first_acc != 2) begin
      n_fail++;
      $display("FAIL stream_latency: first accept %0d first output %0d expected gap 2",
               first_acc, first_out);
    end
    n_vec++;
    if (n_out != 18) begin
      n_fail++;
      $display("FAIL stream_throughput: got %0d outputs in 20 cycles expected 18", n_out);
    end
    in_valid = 1'b0;
    for (int c = 0; c < 10 && sb.size() != 0; c++) begin
      #1;
      if (out_valid === 1'b1) begin
        e = sb.pop_front();
        n_vec++;
        if (q_out !== W'(e.q) || tag_out !== TAG_W'(e.tag)) begin
          n_fail++;
          $display("FAIL stream_drain: got q=%0d tag=%0d expected q=%0d tag=%0d",
                   $signed(q_out), tag_out, e.q, e.tag);
        end
      end
      @(negedge clk);
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL stream_drain_timeout: %0d outstanding expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    randomize_inputs();
    @(negedge clk);
    randomize_inputs();
    @(negedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_precondition: out_valid=%b expected 1", out_valid);
    end
    #1;
    rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || q_out !== '0 || inexact !== 1'b0 || tag_out !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async: valid=%b q=%h inx=%b tag=%h expected all zero",
               out_valid, q_out, inexact, tag_out);
    end
    @(negedge clk);
    randomize_inputs();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_stale[%0d]: out_valid=%b expected 0", c, out_valid);
      end
      @(negedge clk);
    end
    sb.delete();
  endtask

  task automatic test_random();
    bit   prev_stall = 1'b0;
    logic [W-1:0]     pq;
    logic [TAG_W-1:0] pt;
    logic             pi;
    exp_t e;
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom % 10) < 7;
      out_ready = ($urandom % 10) < 6;
      randomize_inputs();
      #1;
      if (prev_stall) begin
        n_vec++;
        if (out_valid !== 1'b1 || q_out !== pq || tag_out !== pt || inexact !== pi) begin
          n_fail++;
          $display("FAIL rand_hold: valid=%b q=%h tag=%h inx=%b expected held q=%h tag=%h inx=%b",
                   out_valid, q_out, tag_out, inexact, pq, pt, pi);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rand_spurious: output with nothing expected");
        end else begin
          e = sb.pop_front();
          if (q_out !== W'(e.q) || inexact !== e.inx || tag_out !== TAG_W'(e.tag)) begin
            n_fail++;
            $display("FAIL rand_result: got q=%0d inx=%b tag=%0d expected q=%0d inx=%b tag=%0d",
                     $signed(q_out), inexact, tag_out, e.q, e.inx, e.tag);
          end
        end
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      pq = q_out; pt = tag_out; pi = inexact;
      if (in_valid && in_ready === 1'b1) push_exp();
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && sb.size() != 0; c++) begin
      #1;
      if (out_valid === 1'b1) begin
        e = sb.pop_front();
        n_vec++;
        if (q_out !== W'(e.q) || inexact !== e.inx || tag_out !== TAG_W'(e.tag)) begin
          n_fail++;
          $display("FAIL rand_drain: got q=%0d tag=%0d expected q=%0d tag=%0d",
                   $signed(q_out), tag_out, e.q, e.tag);
        end
      end
      @(negedge clk);
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL rand_drain_timeout: %0d outstanding expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_exhaustive();
    test_ties();
    test_y0_rsvd();
    test_backpressure();
    test_streaming();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
